// File: rtl/m65c02a_mem_cycle_ctrl.sv
// m65c02a_mem_cycle_ctrl: memory cycle controller that stretches the core's
// Rdy for internal wait states and external device handshakes.
// Ports: Rst/Clk; IO_Op, CE[15:1], Int_WS from core/MMU; Ext_Rdy from devices;
//   Sel_MCC/WE/RE/MCC_DI/MCC_DO status register access; Rdy, Bus_Err out.
// Optional: define MEM_CYC_TIMEOUT_EN to bound external waits to pTO_Cnt
//   clocks, raising Bus_Err and latching {Err, ErrWr, 00, ErrCS} in status.
module m65c02a_mem_cycle_ctrl #(
  parameter int pWS_Out = 2,
  parameter int pTO_Cnt = 255
) (
  input  logic        Rst,
  input  logic        Clk,
  input  logic [1:0]  IO_Op,
  input  logic [15:1] CE,
  input  logic        Int_WS,
  input  logic        Ext_Rdy,
  input  logic        Sel_MCC,
  input  logic        WE,
  input  logic        RE,
  input  logic [7:0]  MCC_DI,
  output logic [7:0]  MCC_DO,
  output logic        Rdy,
  output logic        Bus_Err
);

  typedef enum logic {IDLE, WS} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ext_q, ext_d;
  logic [7:0] stat_q, stat_d;

  logic req, ext, need_wait;
  logic to_hit, rdy_core, clr;
  logic unused_di;

  assign unused_di = ^MCC_DI[6:0];

  assign req       = (IO_Op != 2'b00) & (|CE);
  assign ext       = |CE[15:8];
  assign need_wait = req & (Int_WS | ext);

`ifdef MEM_CYC_TIMEOUT_EN
  logic       wr_q, wr_d;
  logic [3:0] cs_q, cs_d, cs_idx;
  logic [7:0] to_q, to_d;
  logic       to_cond;

  // CE is one-hot; the set bit's index is the chip-select code.
  always_comb begin
    cs_idx = 4'd0;
    for (int i = 1; i < 16; i++)
      if (CE[i]) cs_idx = 4'(i);
  end

  // Timeout only runs once the internal count is exhausted.
  assign to_cond = (state_q == WS) & (cnt_q == 4'd0)
                 & ext_q & ~Ext_Rdy;
  assign to_hit  = to_cond & (to_q == 8'(pTO_Cnt - 1));

  always_comb begin
    wr_d = wr_q;
    cs_d = cs_q;
    to_d = to_q;
    if (state_q == IDLE) begin
      if (need_wait) begin
        wr_d = (IO_Op == 2'b01);
        cs_d = cs_idx;
        to_d = 8'd0;
      end
    end else if (to_cond) begin
      to_d = to_q + 8'd1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_q <= 1'b0;
      cs_q <= 4'd0;
      to_q <= 8'd0;
    end else begin
      wr_q <= wr_d;
      cs_q <= cs_d;
      to_q <= to_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    rdy_core = 1'b1;
    unique case (state_q)
      IDLE: rdy_core = ~need_wait;
      WS:   rdy_core = (cnt_q == 4'd0)
                     & (~ext_q | Ext_Rdy | to_hit);
    endcase
  end

  // Reset forces Rdy high even while request inputs are active.
  assign Rdy     = Rst | rdy_core;
  assign Bus_Err = to_hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ext_d   = ext_q;
    unique case (state_q)
      IDLE: begin
        if (need_wait) begin
          state_d = WS;
          cnt_d   = Int_WS ? 4'(pWS_Out - 1) : 4'd0;
          ext_d   = ext;
        end
      end
      WS: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        if (rdy_core) state_d = IDLE;
      end
    endcase
  end

  // A timeout in the same cycle as a clear wins.
  assign clr = Sel_MCC & WE & Rdy & MCC_DI[7];

  always_comb begin
    stat_d = stat_q;
    if (clr) stat_d = 8'h00;
`ifdef MEM_CYC_TIMEOUT_EN
    if (to_hit) stat_d = {1'b1, wr_q, 2'b00, cs_q};
`endif
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ext_q   <= 1'b0;
      stat_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ext_q   <= ext_d;
      stat_q  <= stat_d;
    end
  end

  assign MCC_DO = (Sel_MCC & RE) ? stat_q : 8'h00;

endmodule

// File: tb/tb_m65c02a_mem_cycle_ctrl.sv
// tb_m65c02a_mem_cycle_ctrl: directed bench for the memory cycle controller.
// Single-cycle vector table plus multi-cycle wait, timeout and reset sequences.
module tb_m65c02a_mem_cycle_ctrl;

  localparam int WS_N = 3;
  localparam int TO_N = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  io_op;
  logic [15:1] ce;
  logic        int_ws, ext_rdy;
  logic        sel, we, re;
  logic [7:0]  di, dout;
  logic        rdy, berr;

  int errs   = 0;
  int checks = 0;

  m65c02a_mem_cycle_ctrl #(
    .pWS_Out(WS_N),
    .pTO_Cnt(TO_N)
  ) dut (
    .Rst(rst), .Clk(clk), .IO_Op(io_op), .CE(ce),
    .Int_WS(int_ws), .Ext_Rdy(ext_rdy), .Sel_MCC(sel),
    .WE(we), .RE(re), .MCC_DI(di), .MCC_DO(dout),
    .Rdy(rdy), .Bus_Err(berr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] io;
    int         cs;
    logic       iws;
    logic       s, w, r;
    logic [7:0] d;
    logic       e_rdy;
    logic [7:0] e_do;
  } vec_t;

  vec_t vt[7];

  function automatic logic [15:1] cs2ce(int cs);
    logic [15:1] v;
    v = '0;
    if (cs >= 1 && cs <= 15) v[cs] = 1'b1;
    return v;
  endfunction

  task automatic chk(string nm, logic [7:0] act,
                     logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    io_op = 2'd0; ce = '0; int_ws = 0;
    sel = 0; we = 0; re = 0; di = 8'h00;
  endtask

  task automatic req(logic [1:0] io, int cs, logic iws);
    io_op = io; ce = cs2ce(cs); int_ws = iws;
  endtask

  // Sample mid-cycle, then advance to just after the next edge.
  task automatic cyc(string nm, logic e_rdy, logic e_berr);
    #2;
    chk({nm, ".rdy"}, {7'd0, rdy}, {7'd0, e_rdy});
    chk({nm, ".berr"}, {7'd0, berr}, {7'd0, e_berr});
    @(posedge clk); #1;
  endtask

  task automatic rd_stat(string nm, logic [7:0] e);
    idle_in(); sel = 1; re = 1;
    #2;
    chk(nm, dout, e);
    @(posedge clk); #1;
    idle_in();
  endtask

  task automatic wr_stat(logic [7:0] d);
    idle_in(); sel = 1; we = 1; di = d;
    @(posedge clk); #1;
    idle_in();
  endtask

  initial begin
    vt[0] = '{2'd0, 9, 1'b1, 0, 0, 0, 8'h00, 1'b1, 8'h00};
    vt[1] = '{2'd2, 0, 1'b1, 0, 0, 0, 8'h00, 1'b1, 8'h00};
    vt[2] = '{2'd2, 1, 1'b0, 0, 0, 0, 8'h00, 1'b1, 8'h00};
    vt[3] = '{2'd3, 7, 1'b0, 0, 0, 0, 8'h00, 1'b1, 8'h00};
    vt[4] = '{2'd1, 4, 1'b0, 1, 0, 1, 8'h00, 1'b1, 8'h00};
    vt[5] = '{2'd0, 0, 1'b0, 1, 0, 0, 8'h00, 1'b1, 8'h00};
    vt[6] = '{2'd0, 0, 1'b0, 1, 1, 1, 8'h7F, 1'b1, 8'h00};

    idle_in(); ext_rdy = 0; rst = 1;
    req(2'd2, 9, 1'b0);
    #2;
    chk("rst.rdy", {7'd0, rdy}, 8'h01);
    chk("rst.berr", {7'd0, berr}, 8'h00);
    @(posedge clk); @(posedge clk); #1;
    rst = 0; idle_in();
    rd_stat("rst.stat", 8'h00);

    for (int i = 0; i < 7; i++) begin
      io_op = vt[i].io; ce = cs2ce(vt[i].cs);
      int_ws = vt[i].iws;
      sel = vt[i].s; we = vt[i].w; re = vt[i].r;
      di = vt[i].d;
      #2;
      chk($sformatf("vec%0d.rdy", i), {7'd0, rdy},
          {7'd0, vt[i].e_rdy});
      chk($sformatf("vec%0d.do", i), dout, vt[i].e_do);
      @(posedge clk); #1;
    end
    idle_in();

    // Internal wait states, two back-to-back requests.
    req(2'd2, 2, 1'b1);
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < WS_N; j++) cyc("iws.lo", 0, 0);
      cyc("iws.hi", 1, 0);
    end
    idle_in();
    cyc("iws.idle", 1, 0);

    // External handshake, CS 8.
    req(2'd1, 8, 1'b0); ext_rdy = 0;
    for (int j = 0; j < 6; j++) cyc("ext.lo", 0, 0);
    ext_rdy = 1;
    cyc("ext.hi", 1, 0);
    idle_in(); ext_rdy = 0;
    cyc("ext.idle", 1, 0);

    // Both: early Ext_Rdy must not shorten the count.
    req(2'd2, 14, 1'b1); ext_rdy = 1;
    for (int j = 0; j < WS_N; j++) cyc("both.lo", 0, 0);
    cyc("both.hi", 1, 0);
    idle_in(); ext_rdy = 0;

    // Hung external cycle, CS 10, write.
    req(2'd1, 10, 1'b0);
`ifdef MEM_CYC_TIMEOUT_EN
    for (int j = 0; j < TO_N; j++) cyc("to.lo", 0, 0);
    cyc("to.hit", 1, 1);
    idle_in();
    cyc("to.after", 1, 0);
    rd_stat("to.stat", 8'hCA);
    wr_stat(8'h7F);
    rd_stat("to.keep", 8'hCA);
    wr_stat(8'h80);
    rd_stat("to.clr", 8'h00);
`else
    for (int j = 0; j < 40; j++) cyc("hang.lo", 0, 0);
    ext_rdy = 1;
    cyc("hang.end", 1, 0);
    idle_in(); ext_rdy = 0;
    rd_stat("hang.stat", 8'h00);
    wr_stat(8'h80);
    rd_stat("hang.clr", 8'h00);
`endif

    // Reset asserted mid-WS.
    req(2'd1, 12, 1'b0); ext_rdy = 0;
    cyc("mrst.idle", 0, 0);
    cyc("mrst.ws", 0, 0);
    sel = 1; re = 1;
    #2; rst = 1; #1;
    chk("mrst.rdy", {7'd0, rdy}, 8'h01);
    chk("mrst.berr", {7'd0, berr}, 8'h00);
    chk("mrst.stat", dout, 8'h00);
    @(posedge clk); #1;
    rst = 0; idle_in();
    cyc("mrst.rel", 1, 0);
    req(2'd2, 3, 1'b1);
    for (int j = 0; j < WS_N; j++) cyc("mrst.lo", 0, 0);
    cyc("mrst.hi", 1, 0);
    idle_in();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim still running at %0t", $time);
    $fatal(1);
  end

endmodule
